ttl_counter_n: RTL and testbench



---
 rtl/ttl_counter_n.sv | 55 +++++
 tb/tb_ttl_counter_n.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ttl_counter_n.sv
// Presettable synchronous counter covering the 74160..169 family: N-bit, binary or decade
// modulus, up/down, parallel load, ENP/ENT enables and a combinational ripple-carry output.
module ttl_counter_n #(
    parameter int unsigned      WIDTH   = 4,
    parameter longint unsigned  MODULUS = 16
) (
    input  logic             CLK,
    input  logic             CLR_n,
    input  logic             LOAD_n,
    input  logic             ENP,
    input  logic             ENT,
    input  logic             U_D,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             RCO
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("ttl_counter_n: WIDTH must be in 1..32");
    end

    if (MODULUS < 64'd2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
        $error("ttl_counter_n: MODULUS must be in 2..2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MOD_MAX = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] q_step;

    // Loaded values above MOD_MAX snap to 0 going up and walk down normally going down.
    always_comb begin
        q_step = Q;
        if (U_D) begin
            if (Q >= MOD_MAX) q_step = '0;
            else              q_step = Q + ONE;
        end else begin
            if (Q == '0) q_step = MOD_MAX;
            else         q_step = Q - ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (!CLR_n)          Q <= '0;
        else if (!LOAD_n)    Q <= D;
        else if (ENP && ENT) Q <= q_step;
    end

    // Terminal count is gated by ENT only, so a cascade stage advances on its neighbour's carry.
    always_comb begin
        RCO = 1'b0;
        if (ENT) RCO = U_D ? (Q == MOD_MAX) : (Q == '0);
    end

endmodule

// File: tb/tb_ttl_counter_n.sv
// Bench for ttl_counter_n: a decade and a binary instance plus a two-stage binary cascade,
// all driven from shared controls and compared against arithmetic reference models.
module tb_ttl_counter_n;

    logic       clk = 1'b0;
    logic       clr_n, load_n, enp, ent, u_d;
    logic [3:0] d, d_hi;
    logic [3:0] q_dec, q_hex, q_lo, q_hi;
    logic       rco_dec, rco_hex, rco_lo, rco_hi;

    int n_checks = 0;
    int n_errors = 0;
    int m_dec, m_hex, m_casc;

    always #5 clk = ~clk;

    ttl_counter_n #(.WIDTH(4), .MODULUS(10)) u_dec (
        .CLK(clk), .CLR_n(clr_n), .LOAD_n(load_n), .ENP(enp), .ENT(ent), .U_D(u_d),
        .D(d), .Q(q_dec), .RCO(rco_dec));

    ttl_counter_n #(.WIDTH(4), .MODULUS(16)) u_hex (
        .CLK(clk), .CLR_n(clr_n), .LOAD_n(load_n), .ENP(enp), .ENT(ent), .U_D(u_d),
        .D(d), .Q(q_hex), .RCO(rco_hex));

    ttl_counter_n #(.WIDTH(4), .MODULUS(16)) u_lo (
        .CLK(clk), .CLR_n(clr_n), .LOAD_n(load_n), .ENP(enp), .ENT(ent), .U_D(u_d),
        .D(d), .Q(q_lo), .RCO(rco_lo));

    ttl_counter_n #(.WIDTH(4), .MODULUS(16)) u_hi (
        .CLK(clk), .CLR_n(clr_n), .LOAD_n(load_n), .ENP(enp), .ENT(rco_lo), .U_D(u_d),
        .D(d_hi), .Q(q_hi), .RCO(rco_hi));

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Single counter stage, straight from the priority/count rules.
    function automatic int ref_next(int q, int m, bit clr, bit ld, bit p, bit t, bit up, int dv);
        if (!clr)       return 0;
        if (!ld)        return dv;
        if (!(p && t))  return q;
        if (up)         return (q >= m - 1) ? 0 : q + 1;
        return (q == 0) ? m - 1 : q - 1;
    endfunction

    function automatic int ref_rco(int q, int m, bit t, bit up);
        return (t && (up ? (q == m - 1) : (q == 0))) ? 1 : 0;
    endfunction

    task automatic check_all();
        check("dec_q",   int'(q_dec), m_dec);
        check("dec_rco", int'(rco_dec), ref_rco(m_dec, 10, ent, u_d));
        check("hex_q",   int'(q_hex), m_hex);
        check("hex_rco", int'(rco_hex), ref_rco(m_hex, 16, ent, u_d));
        check("casc_q",  int'({q_hi, q_lo}), m_casc);
        check("casc_rco", int'(rco_hi), ref_rco(m_casc, 256, ent, u_d));
    endtask

    task automatic step(input bit clr, input bit ld, input bit p, input bit t, input bit up,
                        input int dv, input int dhv);
        clr_n  = clr;
        load_n = ld;
        enp    = p;
        ent    = t;
        u_d    = up;
        d      = 4'(dv);
        d_hi   = 4'(dhv);
        @(posedge clk);
        m_dec = ref_next(m_dec, 10, clr, ld, p, t, up, dv & 15);
        m_hex = ref_next(m_hex, 16, clr, ld, p, t, up, dv & 15);
        // The cascade behaves as one 256-state counter.
        m_casc = ref_next(m_casc, 256, clr, ld, p, t, up, ((dhv & 15) << 4) | (dv & 15));
        #1;
        check_all();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        n_errors++;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        int dec_exp[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        int hex_down[4] = '{1, 0, 15, 14};
        m_dec = 0; m_hex = 0; m_casc = 0;

        // Clear dominates load and enables.
        step(0, 0, 1, 1, 1, 'hA, 'h5);
        check("rst_q", int'(q_hex), 0);
        step(0, 0, 1, 1, 1, 'hA, 'h5);
        check("rst_rco_up", int'(rco_dec), 0);

        // Decade up wrap.
        for (int i = 0; i < 12; i++) begin
            step(1, 1, 1, 1, 1, 0, 0);
            check("dec_up_seq", int'(q_dec), dec_exp[i]);
            check("dec_up_rco", int'(rco_dec), (dec_exp[i] == 9) ? 1 : 0);
        end

        // Binary down wrap after a load of 2.
        step(1, 0, 0, 0, 0, 2, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 1, 1, 0, 0, 0);
            check("hex_down_seq", int'(q_hex), hex_down[i]);
            check("hex_down_rco", int'(rco_hex), (hex_down[i] == 0) ? 1 : 0);
        end
        step(1, 0, 1, 1, 1, 7, 0);
        check("load_over_count", int'(q_hex), 7);

        // Enable gating.
        step(1, 0, 0, 0, 1, 5, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 1, 1, 0, 0);
            check("hold_enp0", int'(q_hex), 5);
        end
        step(1, 1, 1, 0, 1, 0, 0);
        check("hold_ent0", int'(q_hex), 5);
        step(1, 0, 1, 0, 1, 15, 0);
        check("rco_ent0", int'(rco_hex), 0);

        // RCO follows U_D between edges.
        ent = 1'b1;
        #1;
        check("rco_up_tc", int'(rco_hex), 1);
        u_d = 1'b0;
        #1;
        check("rco_ud_flip", int'(rco_hex), 0);
        check("ud_flip_q", int'(q_hex), 15);

        // Out-of-range load on the decade counter.
        step(1, 0, 0, 0, 1, 13, 0);
        step(1, 1, 1, 1, 1, 0, 0);
        check("oor_up", int'(q_dec), 0);
        step(1, 0, 0, 0, 0, 13, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 1, 1, 0, 0, 0);
            check("oor_down", int'(q_dec), 12 - i);
        end

        // Cascade counts 300 edges from zero.
        step(0, 1, 0, 0, 1, 0, 0);
        for (int e = 1; e <= 300; e++) begin
            step(1, 1, 1, 1, 1, 0, 0);
            if (e == 255) check("casc_ff", int'({q_hi, q_lo}), 8'hFF);
            if (e == 256) check("casc_wrap", int'({q_hi, q_lo}), 0);
        end
        check("casc_300", int'({q_hi, q_lo}), 44);

        // Clear on edge 150 restarts the chain.
        step(0, 1, 0, 0, 1, 0, 0);
        for (int e = 1; e <= 160; e++) begin
            step(e != 150, 1, 1, 1, 1, 0, 0);
            if (e == 150) check("casc_clr", int'({q_hi, q_lo}), 0);
        end
        check("casc_after_clr", int'({q_hi, q_lo}), 10);

        // Randomized traffic against the reference models.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 24) != 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1, int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
